// File: rtl/lat_meas_pkg.sv
// Shared types and helpers for the input-to-photon latency tester.
package lat_meas_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRearm,
    StWaitTrig,
    StRun,
    StDone
  } lat_state_t;

  localparam int unsigned LAT_TICK_DIV_DEFAULT = 270;

  // Accumulator width that can hold 2^log2_samples full-scale samples.
  function automatic int unsigned lat_sum_width(input int unsigned res_w,
                                                input int unsigned log2_samples);
    return res_w + log2_samples;
  endfunction

endpackage

// File: rtl/lat_meas_stats.sv
// Per-session min/max/sum/count accumulators for latency samples.
module lat_meas_stats import lat_meas_pkg::*; #(
  parameter int unsigned RES_W        = 16,
  parameter int unsigned LOG2_SAMPLES = 3,
  localparam int unsigned SumW        = lat_sum_width(RES_W, LOG2_SAMPLES),
  localparam int unsigned CntW        = LOG2_SAMPLES + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sample_valid_i,
  input  logic [RES_W-1:0] sample_i,
  output logic [RES_W-1:0] min_o,
  output logic [RES_W-1:0] max_o,
  output logic [SumW-1:0]  sum_o,
  output logic [CntW-1:0]  count_o
);

  logic [RES_W-1:0] min_q, min_d, max_q, max_d;
  logic [SumW-1:0]  sum_q, sum_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (clear_i) begin
      min_d   = '1;
      max_d   = '0;
      sum_d   = '0;
      count_d = '0;
    end else if (sample_valid_i) begin
      if (sample_i < min_q) min_d = sample_i;
      if (sample_i > max_q) max_d = sample_i;
      sum_d   = sum_q + SumW'(sample_i);
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign min_o   = min_q;
  assign max_o   = max_q;
  assign sum_o   = sum_q;
  assign count_o = count_q;

endmodule

// File: rtl/lat_meas.sv
// Multi-sample input-to-photon latency tester: trigger-to-sensor tick counting with
// per-session statistics, plus VSYNC-aligned capture of the test-pattern mode.
module lat_meas import lat_meas_pkg::*; #(
  parameter int unsigned RES_W        = 16,
  parameter int unsigned TICK_DIV     = LAT_TICK_DIV_DEFAULT,
  parameter int unsigned LOG2_SAMPLES = 3
) (
  input  logic                    clk27,
  input  logic                    reset_n,
  input  logic                    active,
  input  logic                    armed,
  input  logic                    sensor,
  input  logic                    trigger,
  input  logic                    VSYNC_in,
  input  logic [1:0]              mode_in,
  output logic [1:0]              mode_synced,
  output logic                    busy,
  output logic                    done,
  output logic [LOG2_SAMPLES:0]   sample_cnt,
  output logic [RES_W-1:0]        result_last,
  output logic [RES_W-1:0]        result_min,
  output logic [RES_W-1:0]        result_max,
  output logic [RES_W-1:0]        result_avg,
  output logic                    timeout
);

  localparam int unsigned SumW = lat_sum_width(RES_W, LOG2_SAMPLES);
  localparam int unsigned CntW = LOG2_SAMPLES + 1;
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] LastIdx = CntW'((1 << LOG2_SAMPLES) - 1);

  lat_state_t       state_q, state_d;
  logic [1:0]       sens_q;
  logic [2:0]       vs_q;
  logic [1:0]       mode_q;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [RES_W-1:0] tick_q, tick_d;
  logic [RES_W-1:0] last_q, last_d, avg_q, avg_d;
  logic             timeout_q, timeout_d;

  logic             sensor_s, enable, sat, run_exit;
  logic [SumW-1:0]  stats_sum, sum_next;
  logic [CntW-1:0]  stats_cnt;

  assign sensor_s = sens_q[1];
  assign enable   = active & armed;
  assign sat      = (tick_q == {RES_W{1'b1}});
  assign run_exit = (state_q == StRun) & (~sensor_s | sat);
  // Sum including the sample being recorded, so the average is ready with done.
  assign sum_next = stats_sum + SumW'(tick_q);

  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    tick_d    = '0;
    last_d    = last_q;
    avg_d     = avg_q;
    timeout_d = timeout_q;
    if (!enable) begin
      state_d   = StIdle;
      last_d    = '0;
      avg_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StRearm;
        StRearm:    if (sensor_s && !trigger) state_d = StWaitTrig;
        StWaitTrig: if (trigger && sensor_s) state_d = StRun;
        StRun: begin
          if (run_exit) begin
            last_d    = tick_q;
            timeout_d = timeout_q | sat;
            if (stats_cnt == LastIdx) begin
              state_d = StDone;
              avg_d   = sum_next[SumW-1:LOG2_SAMPLES];
            end else begin
              state_d = StRearm;
            end
          end else if (presc_q == PreLast) begin
            tick_d = tick_q + RES_W'(1);
          end else begin
            presc_d = presc_q + PreW'(1);
            tick_d  = tick_q;
          end
        end
        StDone:     avg_d = stats_sum[SumW-1:LOG2_SAMPLES];
        default:    state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sens_q    <= 2'b11;
      vs_q      <= '0;
      mode_q    <= '0;
      presc_q   <= '0;
      tick_q    <= '0;
      last_q    <= '0;
      avg_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sens_q    <= {sens_q[0], sensor};
      vs_q      <= {vs_q[1:0], VSYNC_in};
      if (vs_q[2] && !vs_q[1]) mode_q <= mode_in;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      last_q    <= last_d;
      avg_q     <= avg_d;
      timeout_q <= timeout_d;
    end
  end

  lat_meas_stats #(
    .RES_W        (RES_W),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_stats (
    .clk_i          (clk27),
    .rst_ni         (reset_n),
    .clear_i        (~enable),
    .sample_valid_i (run_exit & enable),
    .sample_i       (tick_q),
    .min_o          (result_min),
    .max_o          (result_max),
    .sum_o          (stats_sum),
    .count_o        (stats_cnt)
  );

  assign mode_synced = mode_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign sample_cnt  = stats_cnt;
  assign result_last = last_q;
  assign result_avg  = avg_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_lat_meas.sv
// Scoreboarded bench: u_big uses default tick/width with one sample per session,
// u_small uses 8-bit results, 4-cycle ticks and four samples per session.
module tb_lat_meas;

  logic clk, reset_n, active, armed, armed0, sensor, trigger, vsync;
  logic [1:0] mode_in;

  logic [1:0]  m0, m1;
  logic        busy0, busy1, done0, done1, to0, to1;
  logic [0:0]  cnt0;
  logic [2:0]  cnt1;
  logic [15:0] last0, min0, max0, avg0;
  logic [7:0]  last1, min1, max1, avg1;

  int unsigned q0[$];
  int unsigned q1[$];
  int errors = 0;
  int checks = 0;
  logic pb0 = 1'b0;
  logic pb1 = 1'b0;

  lat_meas #(.RES_W(16), .TICK_DIV(270), .LOG2_SAMPLES(0)) u_big (
    .clk27(clk), .reset_n(reset_n), .active(active), .armed(armed0), .sensor(sensor),
    .trigger(trigger), .VSYNC_in(vsync), .mode_in(mode_in), .mode_synced(m0),
    .busy(busy0), .done(done0), .sample_cnt(cnt0), .result_last(last0),
    .result_min(min0), .result_max(max0), .result_avg(avg0), .timeout(to0)
  );

  lat_meas #(.RES_W(8), .TICK_DIV(4), .LOG2_SAMPLES(2)) u_small (
    .clk27(clk), .reset_n(reset_n), .active(active), .armed(armed), .sensor(sensor),
    .trigger(trigger), .VSYNC_in(vsync), .mode_in(mode_in), .mode_synced(m1),
    .busy(busy1), .done(done1), .sample_cnt(cnt1), .result_last(last1),
    .result_min(min1), .result_max(max1), .result_avg(avg1), .timeout(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every busy fall is a sample exit (or abort) and pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (pb0 && !busy0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_last_big: unexpected exit, got %0d, required none", last0);
        end else chk("sb_last_big", 32'(last0), q0.pop_front());
      end
      if (pb1 && !busy1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_last_small: unexpected exit, got %0d, required none", last1);
        end else chk("sb_last_small", 32'(last1), q1.pop_front());
      end
      pb0 = busy0;
      pb1 = busy1;
    end
  end

  // Trigger from WAIT_TRIG, then make sensor_s low at RUN cycle k (k >= 3).
  task automatic run_sample(input int d, input int k, input int unsigned exp);
    if (d == 0) q0.push_back(exp); else q1.push_back(exp);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    @(negedge clk);
    chk("run_entry_busy", (d == 0) ? 32'(busy0) : 32'(busy1), 1);
    step(k - 2);
    sensor = 1'b0;
    step(4);
    sensor = 1'b1;
    step(6);
  endtask

  initial begin
    reset_n = 1'b0; active = 1'b1; armed = 1'b0; armed0 = 1'b0;
    sensor = 1'b1; trigger = 1'b0; vsync = 1'b1; mode_in = 2'd0;
    step(3);
    @(negedge clk);
    chk("rst_min_small", 32'(min1), 255);
    chk("rst_min_big", 32'(min0), 16'hFFFF);
    chk("rst_max", 32'(max1), 0);
    chk("rst_last", 32'(last1), 0);
    chk("rst_avg", 32'(avg1), 0);
    chk("rst_busy_done", {busy1, done1, to1}, 0);
    chk("rst_cnt", 32'(cnt1), 0);
    chk("rst_mode", 32'(m1), 0);
    reset_n = 1'b1;
    step(2);

    // Statistics session: 10, 20, 30, 41 ticks.
    armed = 1'b1;
    step(4);
    run_sample(1, 40, 10);
    run_sample(1, 80, 20);
    run_sample(1, 120, 30);
    run_sample(1, 165, 41);
    @(negedge clk);
    chk("stats_done", 32'(done1), 1);
    chk("stats_min", 32'(min1), 10);
    chk("stats_max", 32'(max1), 41);
    chk("stats_avg", 32'(avg1), 25);
    chk("stats_cnt", 32'(cnt1), 4);
    chk("stats_timeout", 32'(to1), 0);

    // Disarm clears everything, then rearm guard.
    armed = 1'b0;
    step(1);
    @(negedge clk);
    chk("clr_done", 32'(done1), 0);
    chk("clr_min", 32'(min1), 255);
    chk("clr_avg", 32'(avg1), 0);
    chk("clr_cnt", 32'(cnt1), 0);
    armed = 1'b1;
    step(4);
    q1.push_back(3);
    trigger = 1'b1;
    step(1);
    @(negedge clk);
    chk("guard_entry_busy", 32'(busy1), 1);
    step(10);
    sensor = 1'b0;
    step(4);
    sensor = 1'b1;
    step(10);
    @(negedge clk);
    chk("guard_trig_held", 32'(busy1), 0);
    sensor = 1'b0;
    step(4);
    trigger = 1'b0;
    step(4);
    trigger = 1'b1;
    step(6);
    @(negedge clk);
    chk("guard_sensor_lit", 32'(busy1), 0);
    trigger = 1'b0;
    sensor = 1'b1;
    step(6);
    run_sample(1, 8, 2);
    chk("guard_cnt", 32'(cnt1), 2);

    // Abort mid-RUN at tick 5.
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(20);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy1), 1);
    q1.push_back(0);
    armed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_cnt", 32'(cnt1), 0);
    chk("abort_min", 32'(min1), 255);
    chk("abort_max", 32'(max1), 0);
    chk("abort_timeout", 32'(to1), 0);

    // Saturation: sensor never lit.
    armed = 1'b1;
    step(4);
    q1.push_back(255);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(1025);
    @(negedge clk);
    chk("sat_busy", 32'(busy1), 0);
    chk("sat_timeout", 32'(to1), 1);
    chk("sat_cnt", 32'(cnt1), 1);
    chk("sat_max", 32'(max1), 255);
    chk("sat_done", 32'(done1), 0);

    // Asynchronous reset mid-RUN.
    step(4);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(8);
    @(negedge clk);
    chk("areset_pre_busy", 32'(busy1), 1);
    q1.push_back(0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_busy", 32'(busy1), 0);
    chk("areset_timeout", 32'(to1), 0);
    chk("areset_min", 32'(min1), 255);
    chk("areset_cnt", 32'(cnt1), 0);
    armed = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);

    // Nominal on the default-sized instance: 2700 cycles = 10 ticks.
    armed0 = 1'b1;
    step(4);
    run_sample(0, 2700, 10);
    @(negedge clk);
    chk("nom_done", 32'(done0), 1);
    chk("nom_avg", 32'(avg0), 10);
    chk("nom_minmax", {min0, max0}, {16'd10, 16'd10});
    chk("nom_cnt", 32'(cnt0), 1);
    chk("nom_timeout", 32'(to0), 0);
    chk("small_idle", 32'(busy1), 0);

    // Mode capture on the VSYNC falling edge only.
    mode_in = 2'd2;
    step(5);
    vsync = 1'b0;
    step(2);
    @(negedge clk);
    chk("mode_pre", 32'(m1), 0);
    @(posedge clk);
    @(negedge clk);
    chk("mode_cap_small", 32'(m1), 2);
    chk("mode_cap_big", 32'(m0), 2);
    mode_in = 2'd1;
    step(4);
    @(negedge clk);
    chk("mode_low_hold", 32'(m1), 2);
    vsync = 1'b1;
    step(5);
    @(negedge clk);
    chk("mode_rise_ignored", 32'(m1), 2);

    step(2);
    chk("sb_drained_big", q0.size(), 0);
    chk("sb_drained_small", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
